apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Bus-side APB initiator. Converts simple single-cycle CPU load/store requests into APB transfers.
- Drives the shared APB signals to all peripheral slaves (GPIO, timer, UART, ...).
- Decodes the address into one-hot PSEL and muxes the selected slave's PRDATA/PREADY back to the CPU.
- One transfer outstanding at a time.

Parameters:
- NUM_SLV, 4, number of APB slaves; PSEL/PRDATA/PREADY vector width; 1..16.
- BASE_ADDR, 32'h1000_0000, start of peripheral window; only bits [31:16] are compared.
- SLOT_BITS, 12, log2 of per-slave address region size (4 KiB slots).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  reset.
- req  in  1  CPU transfer request, sampled only in IDLE.
- we  in  1  1=write, 0=read; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  write data; sampled with req.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  decode error (or timeout); valid while ready=1.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  32*NUM_SLV  slave read data; slave i occupies [32*i+31:32*i].
- PREADY  in  NUM_SLV  slave ready, one bit per slave.

Behaviour:
- Single clock PCLK; PRESET is synchronous, active-high, and has priority over all other logic.
- Reset values: state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; rdata=0, ready=0, err=0.
- States: IDLE, SETUP, ACCESS.
- Address decode:
  - hit = (addr[31:16]==BASE_ADDR[31:16]) && (addr[SLOT_BITS+3:SLOT_BITS] < NUM_SLV).
  - slot = addr[SLOT_BITS+3:SLOT_BITS].
- IDLE, req=1 and hit:
  - Latch addr→PADDR, wdata→PWDATA, we→PWRITE, slot→sel register.
  - Next state SETUP.
- IDLE, req=1 and miss:
  - No APB activity.
  - Next cycle: ready=1, err=1, rdata=0. State stays IDLE.
- SETUP (exactly 1 cycle): PSEL[sel]=1, PENABLE=0. Next state ACCESS.
- ACCESS:
  - PSEL[sel]=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - Wait while PREADY[sel]=0; PREADY of unselected slaves is ignored.
  - When PREADY[sel]=1 is sampled:
    - Next cycle: PSEL=0, PENABLE=0, ready=1, err=0.
    - rdata = PRDATA[sel] for reads; rdata unchanged for writes.
    - State returns to IDLE.
- ready is a single-cycle pulse. rdata holds its value until the next completion.
- req is ignored in SETUP/ACCESS; CPU must not issue while busy.
- IDLE accepts a new req in the same cycle ready=1 is high (back-to-back allowed).
- Latency: zero-wait slave gives req@T0 → SETUP@T1 → ACCESS@T2 → ready@T3. Each slave wait cycle adds 1.
- PSEL is never multi-hot. PENABLE=1 only in ACCESS.
- Reset mid-transfer: next edge forces IDLE with all outputs at reset values; no ready pulse for the aborted transfer.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 16) and a counter cleared on entry to ACCESS.
  - If PREADY[sel] is still 0 after TIMEOUT_CYC ACCESS cycles, abort: PSEL/PENABLE drop, ready=1, err=1, rdata=32'hDEAD_BEEF. State returns to IDLE.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Reset: PRESET=1 for 2 cycles → all outputs 0, state IDLE; release → no activity without req.
- Zero-wait write: req, we=1, addr=0x1000_1004, wdata=0xA5, PREADY[1]=1 → T1 PSEL=4'b0010 PENABLE=0; T2 PENABLE=1, PADDR=0x1000_1004, PWDATA=0xA5; T3 ready=1 err=0.
- Wait-state read: addr=0x1000_0008, PREADY[0] asserted 2 cycles into ACCESS with PRDATA[0]=0x0000_003C → ACCESS lasts 2 cycles, then ready=1 with rdata=0x3C; PADDR stable throughout.
- Decode error: addr=0x2000_0000, then addr=0x1000_7000 (slot 7 ≥ NUM_SLV) → no PSEL ever, next-cycle ready=1, err=1, rdata=0.
- Back-to-back + mid-reset: second req in the ready cycle → SETUP next cycle; PRESET asserted during ACCESS → PSEL=PENABLE=0 next edge, no ready.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16: PREADY held 0 → exactly 16 ACCESS cycles, then ready=1, err=1, rdata=0xDEAD_BEEF.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// CPU-side request/response and APB bus signals of the APB master bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives the CPU requests and the APB slave responses.
interface apb_master_bridge_if #(
    parameter int NUM_SLV = 4
);
    // CPU side
    logic                     req;
    logic                     we;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     err;

    // APB side
    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic                     PENABLE;
    logic [31:0]              PWDATA;
    logic [NUM_SLV-1:0]       PSEL;
    logic [32*NUM_SLV-1:0]    PRDATA;
    logic [NUM_SLV-1:0]       PREADY;

    modport master (
        input  req, we, addr, wdata, PRDATA, PREADY,
        output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );

    modport slave (
        output req, we, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single-cycle CPU load/store requests into APB
// SETUP/ACCESS transfers, decodes the address into a one-hot PSEL and returns
// the selected slave's PRDATA with a one-cycle ready pulse.
// Optional feature: define APB_TIMEOUT_EN to add an ACCESS-phase timeout
// (parameter TIMEOUT_CYC) that aborts a stalled transfer with err=1 and
// rdata=32'hDEAD_BEEF. Without the macro ACCESS waits indefinitely.
module apb_master_bridge #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SLOT_BITS = 12
`ifdef APB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 16
`endif
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state_q;
    logic [31:0]        paddr_q;
    logic [31:0]        pwdata_q;
    logic               pwrite_q;
    logic               penable_q;
    logic [NUM_SLV-1:0] psel_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               err_q;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0]   tmo_cnt_q;
`endif

    logic [3:0]         slot_d;
    logic               hit_d;
    logic [NUM_SLV-1:0] slot_oh_d;
    logic               pready_sel;
    logic [31:0]        prdata_sel;

    // Address decode of the incoming CPU request: window hit and one-hot slot.
    always_comb begin
        slot_d    = bus.addr[SLOT_BITS+3:SLOT_BITS];
        hit_d     = (bus.addr[31:16] == BASE_ADDR[31:16]) &&
                    ({1'b0, slot_d} < 5'(NUM_SLV));
        slot_oh_d = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slot_d == 4'(i)) begin
                slot_oh_d[i] = 1'b1;
            end
        end
    end

    // Response mux: the registered one-hot PSEL picks the slave's PREADY/PRDATA,
    // so PREADY of unselected slaves can never complete a transfer.
    always_comb begin
        pready_sel = |(bus.PREADY & psel_q);
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                prdata_sel = prdata_sel | bus.PRDATA[32*i +: 32];
            end
        end
    end

    // Transfer FSM with registered APB and CPU-response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            // ready is a pulse; any branch that completes re-asserts it.
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        if (hit_d) begin
                            paddr_q  <= bus.addr;
                            pwdata_q <= bus.wdata;
                            pwrite_q <= bus.we;
                            psel_q   <= slot_oh_d;
                            state_q  <= SETUP;
                        end else begin
                            // Decode miss: answer immediately, no APB cycle.
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ACCESS: begin
                    if (pready_sel) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b0;
                        if (!pwrite_q) begin
                            rdata_q <= prdata_sel;
                        end
                        state_q   <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Last allowed ACCESS cycle without PREADY: abort.
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'hDEAD_BEEF;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PENABLE = penable_q;
    assign bus.PSEL    = psel_q;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: reset checks, a table of directed
// transfers, randomized transfers against a transaction-level model, and a
// reset-during-ACCESS sequence. The APB slave side reacts to the observed PSEL.
module tb_apb_master_bridge;

    localparam int NUM_SLV = 4;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

    apb_master_bridge #(
        .NUM_SLV  (NUM_SLV),
        .BASE_ADDR(32'h1000_0000),
        .SLOT_BITS(12)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [3:0]  exp_psel;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: latency counted in cycles from the request
    // cycle to the ready cycle (SETUP + ACCESS cycles + 1).
    task automatic model(input logic we, input logic [31:0] addr, input int waits,
                         input logic [31:0] prd, output logic exp_err,
                         output logic [31:0] exp_rdata, output int exp_lat,
                         output logic [3:0] exp_psel);
        int unsigned slot;
        int          acc;
        bit          hit;
        slot = (addr >> 12) % 16;
        hit  = ((addr >> 16) == 32'h1000) && (slot < NUM_SLV);
        if (!hit) begin
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
            exp_lat   = 1;
            exp_psel  = 4'h0;
        end else begin
            acc       = waits + 1;
            exp_err   = 1'b0;
            exp_rdata = we ? model_rdata : prd;
`ifdef APB_TIMEOUT_EN
            if (waits >= 16) begin
                acc       = 16;
                exp_err   = 1'b1;
                exp_rdata = 32'hDEAD_BEEF;
            end
`endif
            exp_lat  = 2 + acc;
            exp_psel = 4'(1 << slot);
        end
        model_rdata = exp_rdata;
    endtask

    // Drive one request (caller sits at a negedge) and act as the APB slaves:
    // unselected slaves always report ready, the selected one waits `waits`
    // ACCESS cycles. Returns what the CPU side and APB side showed.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] prd,
                        output int lat, output logic err, output logic [31:0] rdat,
                        output logic [3:0] psel_first, output logic [31:0] paddr_a,
                        output logic [31:0] pwdata_a, output logic pwrite_a,
                        output logic proto_ok, output logic any_psel);
        int  acc;
        bit  done;
        bus.req    = 1'b1;
        bus.we     = we;
        bus.addr   = addr;
        bus.wdata  = wdata;
        bus.PREADY = '1;
        for (int i = 0; i < NUM_SLV; i++) bus.PRDATA[32*i +: 32] = $urandom;
        lat = 0; acc = 0; done = 0;
        err = 1'b0; rdat = '0; psel_first = '0;
        paddr_a = '0; pwdata_a = '0; pwrite_a = 1'b0;
        proto_ok = 1'b1; any_psel = 1'b0;
        while (!done && lat < 100) begin
            @(negedge PCLK);
            bus.req = 1'b0;
            lat++;
            if (lat == 1) begin
                psel_first = bus.PSEL;
                if (bus.PENABLE) proto_ok = 1'b0;
            end
            if (bus.PSEL != '0) any_psel = 1'b1;
            if ($countones(bus.PSEL) > 1) proto_ok = 1'b0;
            if (bus.PENABLE && bus.PSEL == '0) proto_ok = 1'b0;
            if (bus.ready) begin
                done = 1;
                err  = bus.err;
                rdat = bus.rdata;
                bus.PREADY = '1;
            end else begin
                if (bus.PENABLE) begin
                    acc++;
                    if (acc == 1) begin
                        paddr_a  = bus.PADDR;
                        pwdata_a = bus.PWDATA;
                        pwrite_a = bus.PWRITE;
                    end else if (bus.PADDR !== paddr_a || bus.PWDATA !== pwdata_a ||
                                 bus.PWRITE !== pwrite_a) begin
                        proto_ok = 1'b0;
                    end
                end
                bus.PREADY = (bus.PENABLE && acc > waits) ? '1 : ~bus.PSEL;
                for (int i = 0; i < NUM_SLV; i++) begin
                    bus.PRDATA[32*i +: 32] = bus.PSEL[i] ? prd : $urandom;
                end
            end
        end
        if (!done) lat = -1;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits, input logic [31:0] prd,
                             input logic exp_err, input logic [31:0] exp_rdata,
                             input int exp_lat, input logic [3:0] exp_psel);
        int          lat;
        logic        err, pwrite_a, proto_ok, any_psel;
        logic [31:0] rdat, paddr_a, pwdata_a;
        logic [3:0]  psel_first;
        xfer(we, addr, wdata, waits, prd, lat, err, rdat, psel_first,
             paddr_a, pwdata_a, pwrite_a, proto_ok, any_psel);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " rdata"}, rdat, exp_rdata);
        chk({tag, " setup PSEL"}, 32'(psel_first), 32'(exp_psel));
        chk({tag, " protocol"}, 32'(proto_ok), 32'h1);
        chk({tag, " any PSEL"}, 32'(any_psel), 32'(exp_psel != 4'h0));
        if (exp_psel != 4'h0) begin
            chk({tag, " PADDR"}, paddr_a, addr);
            chk({tag, " PWDATA"}, pwdata_a, wdata);
            chk({tag, " PWRITE"}, 32'(pwrite_a), 32'(we));
        end
    endtask

    initial begin
        int          activity;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        logic [3:0]  e_psel;
        logic        r_we;
        logic [31:0] r_addr, r_wdata, r_prd;
        int          r_waits;

        //          we    addr            wdata          waits prd            err   rdata          lat psel
        tbl[0] = '{1'b1, 32'h1000_1004, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 3, 4'b0010};
        tbl[1] = '{1'b0, 32'h1000_0008, 32'h0,         1, 32'h0000_003C, 1'b0, 32'h0000_003C, 4, 4'b0001};
        tbl[2] = '{1'b0, 32'h2000_0000, 32'h0,         0, 32'h1111_1111, 1'b1, 32'h0000_0000, 1, 4'b0000};
        tbl[3] = '{1'b0, 32'h1000_7000, 32'h0,         0, 32'h2222_2222, 1'b1, 32'h0000_0000, 1, 4'b0000};
        tbl[4] = '{1'b0, 32'h1000_3FFC, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 6, 4'b1000};
        tbl[5] = '{1'b1, 32'h1000_2000, 32'hCAFE_F00D, 0, 32'h3333_3333, 1'b0, 32'h1234_5678, 3, 4'b0100};
        tbl[6] = '{1'b0, 32'h1001_0000, 32'h0,         0, 32'h4444_4444, 1'b1, 32'h0000_0000, 1, 4'b0000};
        tbl[7] = '{1'b1, 32'h1000_4000, 32'h5555_5555, 0, 32'h6666_6666, 1'b1, 32'h0000_0000, 1, 4'b0000};
        tbl[8] = '{1'b0, 32'h1000_2010, 32'h0,         2, 32'h8765_4321, 1'b0, 32'h8765_4321, 5, 4'b0100};

        // Reset for two cycles with no request pending.
        PRESET     = 1'b1;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.PREADY = '0;
        bus.PRDATA = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset PSEL", 32'(bus.PSEL), 32'h0);
        chk("reset PENABLE", 32'(bus.PENABLE), 32'h0);
        chk("reset PWRITE", 32'(bus.PWRITE), 32'h0);
        chk("reset PADDR", bus.PADDR, 32'h0);
        chk("reset PWDATA", bus.PWDATA, 32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset ready", 32'(bus.ready), 32'h0);
        chk("reset err", 32'(bus.err), 32'h0);
        PRESET = 1'b0;
        activity = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (bus.PSEL != '0 || bus.PENABLE || bus.ready) activity++;
        end
        chk("idle after reset activity", activity, 0);

        // Directed table, issued back-to-back (next req in the ready cycle).
        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                      tbl[i].waits, tbl[i].prd, tbl[i].exp_err, tbl[i].exp_rdata,
                      tbl[i].exp_lat, tbl[i].exp_psel);
        end
        model_rdata = tbl[8].exp_rdata;

        // ready must be a single-cycle pulse when no new request follows.
        @(negedge PCLK);
        chk("ready pulse width", 32'(bus.ready), 32'h0);
        chk("rdata hold", bus.rdata, model_rdata);

        // Randomized transfers against the model, with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            r_we    = 1'($urandom % 2);
            r_wdata = $urandom;
            r_prd   = $urandom;
            r_waits = int'($urandom % 4);
            if ($urandom % 8 == 0) r_addr = $urandom;
            else r_addr = 32'h1000_0000 | (($urandom % 8) << 12) | ($urandom % 4096);
            model(r_we, r_addr, r_waits, r_prd, e_err, e_rd, e_lat, e_psel);
            run_check($sformatf("rnd%0d", n), r_we, r_addr, r_wdata, r_waits, r_prd,
                      e_err, e_rd, e_lat, e_psel);
            repeat ($urandom % 3) @(negedge PCLK);
        end

`ifdef APB_TIMEOUT_EN
        // Slave never answers: 16 ACCESS cycles, then an error completion.
        model(1'b0, 32'h1000_0010, 40, 32'h0, e_err, e_rd, e_lat, e_psel);
        run_check("timeout", 1'b0, 32'h1000_0010, 32'h0, 40, 32'h0,
                  1'b1, 32'hDEAD_BEEF, 18, 4'b0001);
`endif

        // Reset asserted while a transfer sits in ACCESS.
        @(negedge PCLK);
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 32'h1000_3000;
        bus.PREADY = '0;
        @(negedge PCLK);
        bus.req = 1'b0;
        @(negedge PCLK);
        chk("midrst in ACCESS", 32'(bus.PENABLE), 32'h1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst PSEL", 32'(bus.PSEL), 32'h0);
        chk("midrst PENABLE", 32'(bus.PENABLE), 32'h0);
        chk("midrst ready", 32'(bus.ready), 32'h0);
        chk("midrst PADDR", bus.PADDR, 32'h0);
        chk("midrst rdata", bus.rdata, 32'h0);
        PRESET     = 1'b0;
        bus.PREADY = '1;
        activity = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (bus.PSEL != '0 || bus.PENABLE || bus.ready) activity++;
        end
        chk("after midrst activity", activity, 0);

        // A fresh transfer works after the aborted one.
        model_rdata = 32'h0;
        model(1'b0, 32'h1000_1000, 0, 32'h0BAD_F00D, e_err, e_rd, e_lat, e_psel);
        run_check("post-reset", 1'b0, 32'h1000_1000, 32'h0, 0, 32'h0BAD_F00D,
                  e_err, e_rd, e_lat, e_psel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
